// File: rtl/assoc_cache_ctrl_pkg.sv
// assoc_cache_ctrl_pkg: shared cache types, FSM states, width helpers and pseudo-LRU functions.
package assoc_cache_ctrl_pkg;
  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;
  localparam int MEM_LINE_WORDS = 4;
  localparam int MEM_LINE_W = MEM_LINE_WORDS * CPU_DATA_W;
  typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH} state_t;
  typedef struct packed {
    logic valid;
    logic rw;
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] data;
  } cpu_req_t;
  typedef struct packed {
    logic ready;
    logic [CPU_DATA_W-1:0] data;
  } cpu_res_t;
  typedef struct packed {
    logic valid;
    logic rw;
    logic [CPU_ADDR_W-1:0] addr;
    logic [MEM_LINE_W-1:0] data;
  } mem_req_t;
  typedef struct packed {
    logic ready;
    logic [MEM_LINE_W-1:0] data;
  } mem_data_t;
  function automatic int index_w(int sets);
    return $clog2(sets);
  endfunction
  function automatic int offset_w(int line_words, int data_w);
    return $clog2(line_words) + $clog2(data_w / 8);
  endfunction
  function automatic int tag_w(int addr_w, int sets, int line_words, int data_w);
    return addr_w - index_w(sets) - offset_w(line_words, data_w);
  endfunction
  // Tree bits point toward the least-recently-used side: [0] root, [1] ways 0/1, [2] ways 2/3.
  function automatic logic [2:0] plru_touch(logic [2:0] b, int way, int ways);
    logic [2:0] n;
    n = b;
    if (ways == 2) n[0] = (way == 0);
    else if (ways == 4) begin
      n[0] = (way < 2);
      if (way < 2) n[1] = (way == 0);
      else n[2] = (way == 2);
    end
    return n;
  endfunction
  function automatic int plru_victim(logic [2:0] b, int ways);
    return ways == 4 ? (b[0] ? (b[2] ? 3 : 2) : (b[1] ? 1 : 0)) : ways == 2 ? int'(b[0]) : 0;
  endfunction
endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: one way of tag/valid/dirty/line storage, combinational read, synchronous write.
module cache_way_array #(
  parameter int SETS = 1024,
  parameter int TAG_W = 18,
  parameter int LINE_W = 128,
  parameter int IDX_W = $clog2(SETS)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              we,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);
  logic [SETS-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [SETS];
  logic [LINE_W-1:0] lines [SETS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[idx] <= wr_valid;
      dirty[idx] <= wr_dirty;
    end
  // Tag and data storage are left uninitialised by reset.
  always_ff @(posedge clk)
    if (we) begin
      tags[idx] <= wr_tag;
      lines[idx] <= wr_line;
    end
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag = tags[idx];
  assign rd_line = lines[idx];
endmodule

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: set-associative write-back cache controller with pseudo-LRU and full flush.
module assoc_cache_ctrl
  import assoc_cache_ctrl_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 1024,
  parameter int LINE_WORDS = MEM_LINE_WORDS,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
)(
  input  logic      clk,
  input  logic      rst_n,
  input  cpu_req_t  cpu_req,
  input  logic      flush_req,
  output cpu_res_t  cpu_res,
  output logic      flush_done,
  output mem_req_t  mem_req,
  input  mem_data_t mem_data
);
  localparam int INDEX_W = index_w(SETS);
  localparam int OFFSET_W = offset_w(LINE_WORDS, DATA_W);
  localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS, DATA_W);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int LRU_W = WAYS == 4 ? 3 : 1;
  state_t state;
  logic [INDEX_W-1:0] fset, req_idx, idx;
  logic [WAY_W-1:0] fway, victim, hit_way, vict_c;
  logic [SETS-1:0][LRU_W-1:0] lru;
  logic [TAG_W-1:0] req_tag, wr_tag;
  logic [WORD_W-1:0] req_word;
  logic [ADDR_W-1:0] line_addr;
  logic [WAYS-1:0] rd_valid, rd_dirty, we;
  logic [TAG_W-1:0] rd_tag [WAYS];
  logic [LINE_W-1:0] rd_line [WAYS];
  logic [LINE_W-1:0] wr_line, hit_line;
  logic hit, vdirty, fl_adv, fl_last, fway_last, wr_valid, wr_dirty;
  assign req_idx = INDEX_W'(cpu_req.addr >> OFFSET_W);
  assign req_word = WORD_W'(cpu_req.addr >> BYTE_W);
  assign req_tag = TAG_W'(cpu_req.addr >> (OFFSET_W + INDEX_W));
  assign line_addr = cpu_req.addr & ~ADDR_W'((1 << OFFSET_W) - 1);
  assign idx = state == FLUSH ? fset : req_idx;
  assign vdirty = rd_valid[vict_c] && rd_dirty[vict_c];
  assign fway_last = fway == WAY_W'(WAYS - 1);
  assign fl_last = fway_last && fset == INDEX_W'(SETS - 1);
  assign fl_adv = state == FLUSH && (mem_req.valid ? mem_data.ready : !(rd_valid[fway] && rd_dirty[fway]));
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_array #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
      .clk(clk), .rst_n(rst_n), .idx(idx),
      .rd_valid(rd_valid[w]), .rd_dirty(rd_dirty[w]), .rd_tag(rd_tag[w]), .rd_line(rd_line[w]),
      .we(we[w]), .wr_valid(wr_valid), .wr_dirty(wr_dirty), .wr_tag(wr_tag), .wr_line(wr_line)
    );
  end
  // Descending scan so the lowest-index invalid way overrides the pseudo-LRU choice.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    vict_c = WAY_W'(plru_victim(3'(lru[req_idx]), WAYS));
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (rd_valid[i] && rd_tag[i] == req_tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!rd_valid[i]) vict_c = WAY_W'(i);
    end
    hit_line = rd_line[hit_way];
    hit_line[req_word*DATA_W +: DATA_W] = cpu_req.data;
  end
  always_comb begin
    we = '0;
    wr_valid = 1'b0;
    wr_dirty = 1'b0;
    wr_tag = req_tag;
    wr_line = hit_line;
    if (state == COMPARE && hit && cpu_req.rw) begin
      we[hit_way] = 1'b1;
      wr_valid = 1'b1;
      wr_dirty = 1'b1;
    end else if (state == ALLOCATE && mem_data.ready) begin
      we[victim] = 1'b1;
      wr_valid = 1'b1;
      wr_line = mem_data.data;
    end else if (fl_adv) begin
      we[fway] = 1'b1;
      wr_tag = rd_tag[fway];
      wr_line = rd_line[fway];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cpu_res <= '0;
      mem_req <= '0;
      flush_done <= 1'b0;
      fset <= '0;
      fway <= '0;
      victim <= '0;
      lru <= '0;
    end else begin
      cpu_res.ready <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: state <= flush_req ? FLUSH : cpu_req.valid ? COMPARE : IDLE;
        COMPARE:
          if (hit) begin
            cpu_res.ready <= 1'b1;
            cpu_res.data <= rd_line[hit_way][req_word*DATA_W +: DATA_W];
            lru[req_idx] <= LRU_W'(plru_touch(3'(lru[req_idx]), int'(hit_way), WAYS));
            state <= IDLE;
          end else begin
            victim <= vict_c;
            state <= vdirty ? WRITE_BACK : ALLOCATE;
            mem_req.valid <= 1'b1;
            mem_req.rw <= vdirty;
            mem_req.addr <= vdirty ? {rd_tag[vict_c], req_idx, OFFSET_W'(0)} : line_addr;
            mem_req.data <= rd_line[vict_c];
          end
        WRITE_BACK:
          if (mem_data.ready) begin
            mem_req.rw <= 1'b0;
            mem_req.addr <= line_addr;
            state <= ALLOCATE;
          end
        ALLOCATE:
          if (mem_data.ready) begin
            mem_req.valid <= 1'b0;
            state <= COMPARE;
          end
        FLUSH:
          if (fl_adv) begin
            mem_req.valid <= 1'b0;
            fway <= fway_last ? '0 : fway + 1'b1;
            if (fway_last) fset <= fset + 1'b1;
            if (fl_last) begin
              flush_done <= 1'b1;
              state <= IDLE;
            end
          end else if (!mem_req.valid) begin
            mem_req.valid <= 1'b1;
            mem_req.rw <= 1'b1;
            mem_req.addr <= {rd_tag[fway], fset, OFFSET_W'(0)};
            mem_req.data <= rd_line[fway];
          end
        default: state <= IDLE;
      endcase
    end
endmodule
